rr_stream_arbiter: RTL and testbench

RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

---
 rtl/rr_stream_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_rr_stream_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
//   Four-input round-robin stream arbiter with packet locking. A source that
//   wins a grant keeps the output until it delivers a beat flagged last. The
//   round-robin pointer only advances when a packet completes, so a packet is
//   never interleaved with beats from another source.
//
// Ports
//   clk           rising-edge clock
//   s_rst         synchronous active-high reset
//   start         grant enable for new packets (an open packet always completes)
//   src_vaild     [3:0]          per-source beat valid
//   src_data_in   [4*WIDTH-1:0]  per-source data, source i at [i*WIDTH +: WIDTH]
//   src_last      [3:0]          per-source end-of-packet flag
//   src_ready     [3:0]          per-source ready (combinational, at most one high)
//   dst_ready     downstream ready
//   dst_vaild     registered output valid
//   dst_data_out  [WIDTH-1:0]    registered output data
//   dst_last      registered output end-of-packet flag
//   dst_id        [1:0]          registered source index of the output beat
//   busy          registered, high while a packet is locked
// -----------------------------------------------------------------------------
module rr_stream_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               s_rst,
  input  logic               start,
  input  logic [3:0]         src_vaild,
  input  logic [4*WIDTH-1:0] src_data_in,
  input  logic [3:0]         src_last,
  output logic [3:0]         src_ready,
  input  logic               dst_ready,
  output logic               dst_vaild,
  output logic [WIDTH-1:0]   dst_data_out,
  output logic               dst_last,
  output logic [1:0]         dst_id,
  output logic               busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_owner;
  logic [1:0]         w_owner_nxt;
  logic [1:0]         r_ptr;
  logic [1:0]         w_ptr_nxt;
  logic               r_busy;
  logic               r_dst_vaild;
  logic [WIDTH-1:0]   r_dst_data;
  logic               r_dst_last;
  logic [1:0]         r_dst_id;

  logic               w_load;
  logic [2:0]         w_pick;
  logic               w_any;
  logic [1:0]         w_sel;
  logic [3:0]         w_src_ready;
  logic [1:0]         w_acc_idx;
  logic               w_accept;
  logic               w_acc_last;
  logic [WIDTH-1:0]   w_acc_data;

  // Returns {found, index} of the first valid source scanning ptr, ptr+1, ...
  // The loop runs from the lowest priority upward so the highest-priority
  // hit (offset 0) is the final writer.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] vld);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (vld[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // The output register can take a new beat when empty or being drained.
  assign w_load = dst_ready | ~r_dst_vaild;
  assign w_pick = rr_pick(r_ptr, src_vaild);
  assign w_any  = w_pick[2];
  assign w_sel  = w_pick[1:0];

  // Grant decode: one-hot ready for the selected (IDLE) or locked (LOCK) source.
  always_comb begin
    w_src_ready = 4'b0000;
    w_acc_idx   = r_owner;
    case (r_state)
      ST_IDLE: begin
        w_acc_idx = w_sel;
        if (start && w_load && w_any) begin
          w_src_ready = 4'b0001 << w_sel;
        end else begin
          w_src_ready = 4'b0000;
        end
      end
      ST_LOCK: begin
        w_acc_idx = r_owner;
        if (w_load) begin
          w_src_ready = 4'b0001 << r_owner;
        end else begin
          w_src_ready = 4'b0000;
        end
      end
      default: begin
        w_acc_idx   = 2'd0;
        w_src_ready = 4'b0000;
      end
    endcase
  end

  assign src_ready  = w_src_ready;
  assign w_accept   = |(src_vaild & w_src_ready);
  assign w_acc_last = src_last[w_acc_idx];
  assign w_acc_data = src_data_in[int'(w_acc_idx)*WIDTH +: WIDTH];

  // Next-state logic: lock on a non-last beat, release and advance ptr on a last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_acc_last) begin
            w_ptr_nxt = w_sel + 2'd1;
          end else begin
            w_state_nxt = ST_LOCK;
            w_owner_nxt = w_sel;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (w_accept && w_acc_last) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = r_owner + 2'd1;
        end else begin
          w_state_nxt = ST_LOCK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, owner, pointer and busy flag registers.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == ST_LOCK);
    end
  end

  // Output register: advances only when it can load; payload holds when no beat is taken.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_dst_vaild <= 1'b0;
      r_dst_data  <= '0;
      r_dst_last  <= 1'b0;
      r_dst_id    <= 2'd0;
    end else if (w_load) begin
      r_dst_vaild <= w_accept;
      if (w_accept) begin
        r_dst_data <= w_acc_data;
        r_dst_last <= w_acc_last;
        r_dst_id   <= w_acc_idx;
      end
    end
  end

  assign dst_vaild    = r_dst_vaild;
  assign dst_data_out = r_dst_data;
  assign dst_last     = r_dst_last;
  assign dst_id       = r_dst_id;
  assign busy         = r_busy;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_arbiter
//   Drives directed scenarios and randomized traffic into rr_stream_arbiter and
//   compares every cycle against a behavioural model: an owner index (-1 when
//   no packet is open), a rotating start index, and a copy of the output beat.
// -----------------------------------------------------------------------------
module tb_rr_stream_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           s_rst;
  logic           start;
  logic [3:0]     src_vaild;
  logic [4*W-1:0] src_data_in;
  logic [3:0]     src_last;
  logic [3:0]     src_ready;
  logic           dst_ready;
  logic           dst_vaild;
  logic [W-1:0]   dst_data_out;
  logic           dst_last;
  logic [1:0]     dst_id;
  logic           busy;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  int         m_owner;
  int         m_ptr;
  logic       m_vld;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] m_id;

  rr_stream_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .s_rst        (s_rst),
    .start        (start),
    .src_vaild    (src_vaild),
    .src_data_in  (src_data_in),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .dst_ready    (dst_ready),
    .dst_vaild    (dst_vaild),
    .dst_data_out (dst_data_out),
    .dst_last     (dst_last),
    .dst_id       (dst_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_vld   = 1'b0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    m_id    = 2'd0;
  endtask

  // One clock cycle: drive inputs, check ready against the model, advance the
  // model by the spec rules, then check the registered outputs.
  task automatic step(input logic rst, input logic st, input logic [3:0] vld,
                      input logic [3:0] lst, input logic [31:0] data, input logic drdy);
    logic [3:0] exp_rdy;
    bit         load;
    int         acc;
    int         idx;
    @(negedge clk);
    s_rst       = rst;
    start       = st;
    src_vaild   = vld;
    src_last    = lst;
    src_data_in = data;
    dst_ready   = drdy;
    #1;
    load    = drdy || !m_vld;
    exp_rdy = 4'b0000;
    if (m_owner < 0) begin
      if (st && load) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (vld[idx] && exp_rdy == 4'b0000) exp_rdy[idx] = 1'b1;
        end
      end
    end else if (load) begin
      exp_rdy[m_owner] = 1'b1;
    end
    if (!rst) begin
      check_eq("src_ready", {28'd0, src_ready}, {28'd0, exp_rdy});
    end
    acc = -1;
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && exp_rdy[i]) acc = i;
    end
    if (rst) begin
      model_reset();
    end else begin
      if (load) begin
        m_vld = (acc >= 0);
        if (acc >= 0) begin
          m_data = data[acc*8 +: 8];
          m_last = lst[acc];
          m_id   = acc[1:0];
        end
      end
      if (acc >= 0) begin
        if (lst[acc]) begin
          m_owner = -1;
          m_ptr   = (acc + 1) % 4;
        end else begin
          m_owner = acc;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("dst_vaild", {31'd0, dst_vaild}, {31'd0, m_vld});
    check_eq("dst_data",  {24'd0, dst_data_out}, {24'd0, m_data});
    check_eq("dst_last",  {31'd0, dst_last}, {31'd0, m_last});
    check_eq("dst_id",    {30'd0, dst_id}, {30'd0, m_id});
    check_eq("busy",      {31'd0, busy}, {31'd0, (m_owner >= 0)});
  endtask

  task automatic idle_rst();
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1);
  endtask

  function automatic logic [3:0] rand_bits(input int pct);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  initial begin
    s_rst = 1'b1; start = 1'b0; src_vaild = 4'h0; src_last = 4'h0;
    src_data_in = '0; dst_ready = 1'b1;
    model_reset();
    idle_rst();
    idle_rst();

    // Fairness: every source always offers single-beat packets.
    for (int n = 0; n < 12; n++) begin
      step(1'b0, 1'b1, 4'hF, 4'hF, $urandom, 1'b1);
      check_eq("fair_id", {30'd0, dst_id}, n % 4);
      check_eq("fair_vld", {31'd0, dst_vaild}, 32'd1);
    end

    // Packet lock: source 2 opens a 3-beat packet, source 1 waits.
    idle_rst();
    step(1'b0, 1'b1, 4'b0100, 4'b0010, 32'h00A0_0000, 1'b1);
    check_eq("lock_a0", {24'd0, dst_data_out}, 32'hA0);
    step(1'b0, 1'b1, 4'b0110, 4'b0010, 32'h00A1_0011, 1'b1);
    check_eq("lock_a1", {24'd0, dst_data_out}, 32'hA1);
    step(1'b0, 1'b1, 4'b0110, 4'b0110, 32'h00A2_0011, 1'b1);
    check_eq("lock_a2", {24'd0, dst_data_out}, 32'hA2);
    check_eq("lock_id", {30'd0, dst_id}, 32'd2);
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 32'h0000_0011, 1'b1);
    check_eq("lock_next", {30'd0, dst_id}, 32'd1);

    // Backpressure: hold 0x5A for five stalled cycles.
    idle_rst();
    step(1'b0, 1'b1, 4'b0001, 4'b0001, 32'h0000_005A, 1'b1);
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b1, 4'hF, 4'hF, 32'h1122_3344, 1'b0);
      check_eq("bp_hold", {24'd0, dst_data_out}, 32'h5A);
    end
    step(1'b0, 1'b1, 4'hF, 4'hF, 32'h1122_3344, 1'b1);
    check_eq("bp_release", {30'd0, dst_id}, 32'd1);

    // start drops during a 4-beat packet from source 3; packet completes.
    idle_rst();
    step(1'b0, 1'b0, 4'hF, 4'h0, 32'h0, 1'b1);
    check_eq("start_gate", {31'd0, dst_vaild}, 32'd0);
    step(1'b0, 1'b1, 4'b1000, 4'h0, 32'hD0_00_00_00, 1'b1);
    step(1'b0, 1'b0, 4'b1001, 4'h0, 32'hD1_00_00_00, 1'b1);
    // Owner stall for three cycles while source 0 waits.
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, 4'b0001, 4'h1, 32'h0, 1'b1);
      check_eq("stall_busy", {31'd0, busy}, 32'd1);
    end
    step(1'b0, 1'b0, 4'b1001, 4'h1, 32'hD2_00_00_00, 1'b1);
    step(1'b0, 1'b0, 4'b1001, 4'h9, 32'hD3_00_00_00, 1'b1);
    check_eq("start_last", {31'd0, dst_last}, 32'd1);
    step(1'b0, 1'b0, 4'b0001, 4'h1, 32'h0, 1'b1);
    check_eq("start_idle", {31'd0, dst_vaild}, 32'd0);

    // Reset mid-packet, then lowest valid index wins.
    step(1'b0, 1'b1, 4'b1000, 4'h0, 32'hE0_00_00_00, 1'b1);
    step(1'b0, 1'b1, 4'b1000, 4'h0, 32'hE1_00_00_00, 1'b1);
    idle_rst();
    check_eq("rst_vld", {31'd0, dst_vaild}, 32'd0);
    step(1'b0, 1'b1, 4'b1010, 4'b1010, 32'h0, 1'b1);
    check_eq("rst_grant", {30'd0, dst_id}, 32'd1);

    // Randomized traffic with varying knobs.
    for (int ph = 0; ph < 4; ph++) begin
      int pv, pl, ps, pr;
      pv = 30 + ph * 20;
      pl = 20 + ph * 15;
      ps = 60 + ph * 10;
      pr = 90 - ph * 20;
      for (int n = 0; n < 600; n++) begin
        step(($urandom_range(299) == 0), ($urandom_range(99) < ps), rand_bits(pv),
             rand_bits(pl), $urandom, ($urandom_range(99) < pr));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
